// File: rtl/control_sequencer_if.sv
// Strobe and status bundle between the control sequencer (master) and the datapath (slave).
// Run, MemRdy and IR flow into the sequencer; every bus, load and ALU strobe flows out.
interface control_sequencer_if #(
   parameter int NREG = 16,
   parameter int ALUW = 4
);
   logic            Run;
   logic            MemRdy;
   logic [31:0]     IR;
   logic            PCout;
   logic            Zlowout;
   logic            MDRout;
   logic            MARin;
   logic            Zin;
   logic            PCin;
   logic            MDRin;
   logic            IRin;
   logic            Yin;
   logic            IncPC;
   logic            Read;
   logic [NREG-1:0] Rin;
   logic [NREG-1:0] Rout;
   logic [ALUW-1:0] AluOp;
   logic            Busy;
   logic            Halted;
   logic            Illegal;

   modport master (
      input  Run, MemRdy, IR,
      output PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read,
             Rin, Rout, AluOp, Busy, Halted, Illegal
   );

   modport slave (
      output Run, MemRdy, IR,
      input  PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read,
             Rin, Rout, AluOp, Busy, Halted, Illegal
   );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore controller for the single-bus datapath: fetch (T0-T2), reg-reg ALU
// execute (T3-T5), NOP and HALT, with T1 memory wait states and Run gating.
module control_sequencer #(
   parameter int NREG = 16,
   parameter int OPW  = 5,
   parameter int ALUW = 4
) (
   input  logic                 Clock,
   input  logic                 Resetn,
   control_sequencer_if.master  cs
);

   typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, HALT} state_t;

   typedef struct packed {
      logic pc_out;
      logic zlow_out;
      logic mdr_out;
      logic mar_in;
      logic z_in;
      logic pc_in;
      logic mdr_in;
      logic ir_in;
      logic inc_pc;
      logic read;
      logic busy;
      logic halted;
   } strobe_t;

   localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
   localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
   localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
   localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
   localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
   localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

   state_t          state;
   state_t          state_nxt;
   strobe_t         strb;

   logic [OPW-1:0]  opcode;
   logic [3:0]      ra;
   logic [3:0]      rb;
   logic [3:0]      rc;
   logic            is_alu;
   logic            regs_ok;
   logic            alu_ok;
   logic            illegal_op;
   logic [ALUW-1:0] alu_code;

   logic            y_in;
   logic [NREG-1:0] rin;
   logic [NREG-1:0] rout;
   logic [ALUW-1:0] alu_op;
   logic            illegal;
   logic            unused_ir;

   assign opcode    = cs.IR[31 -: OPW];
   assign ra        = cs.IR[26:23];
   assign rb        = cs.IR[22:19];
   assign rc        = cs.IR[18:15];
   assign unused_ir = ^cs.IR[14:0];

   assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                   (opcode == OP_AND) || (opcode == OP_OR);

   // Register fields can only fall outside the file when it has fewer than 16 entries.
   if (NREG < 16) begin : g_range
      assign regs_ok = (ra < 4'(NREG)) && (rb < 4'(NREG)) && (rc < 4'(NREG));
   end else begin : g_full
      assign regs_ok = 1'b1;
   end

   assign alu_ok     = is_alu && regs_ok;
   assign illegal_op = !(is_alu || (opcode == OP_NOP) || (opcode == OP_HALT)) ||
                       (is_alu && !regs_ok);

   always_comb begin
      case (opcode)
         OP_ADD:  alu_code = ALUW'(1);
         OP_SUB:  alu_code = ALUW'(2);
         OP_AND:  alu_code = ALUW'(3);
         OP_OR:   alu_code = ALUW'(4);
         default: alu_code = '0;
      endcase
   end

   function automatic logic [NREG-1:0] onehot(input logic [3:0] idx);
      logic [NREG-1:0] v;
      v = '0;
      for (int i = 0; i < NREG; i++)
         if (idx == 4'(i)) v[i] = 1'b1;
      return v;
   endfunction

   function automatic strobe_t strobes_for(input state_t s);
      strobe_t o;
      o = '0;
      case (s)
         T0: begin
            o.pc_out = 1'b1; o.mar_in = 1'b1; o.inc_pc = 1'b1; o.z_in = 1'b1; o.busy = 1'b1;
         end
         T1: begin
            o.zlow_out = 1'b1; o.pc_in = 1'b1; o.read = 1'b1; o.mdr_in = 1'b1; o.busy = 1'b1;
         end
         T2: begin
            o.mdr_out = 1'b1; o.ir_in = 1'b1; o.busy = 1'b1;
         end
         T3:      o.busy = 1'b1;
         T4: begin
            o.z_in = 1'b1; o.busy = 1'b1;
         end
         T5: begin
            o.zlow_out = 1'b1; o.busy = 1'b1;
         end
         HALT:    o.halted = 1'b1;
         default: o = '0;
      endcase
      return o;
   endfunction

   // NOTE: every variable assigned in an always_comb gets a value before any branch,
   // otherwise an untaken path holds its old value and synthesis infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (cs.Run) state_nxt = T0;
         T0:   state_nxt = T1;
         T1:   if (cs.MemRdy) state_nxt = T2;
         T2:   state_nxt = T3;
         T3: begin
            if (opcode == OP_HALT) state_nxt = HALT;
            else if (alu_ok)       state_nxt = T4;
            else                   state_nxt = cs.Run ? T0 : IDLE;
         end
         T4:   state_nxt = T5;
         T5:   state_nxt = cs.Run ? T0 : IDLE;
         HALT: state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: strobes are registered from the next state so they settle just after the
   // edge that enters their state; non-blocking assignments keep state and strobes in step.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state <= IDLE;
         strb  <= '0;
      end else begin
         state <= state_nxt;
         strb  <= strobes_for(state_nxt);
      end
   end

   // IR is only loaded on the edge that enters T3, so its fields are decoded against the
   // registered state rather than pre-registered with the other strobes.
   always_comb begin
      y_in    = 1'b0;
      rin     = '0;
      rout    = '0;
      alu_op  = '0;
      illegal = 1'b0;
      case (state)
         T3: begin
            y_in    = alu_ok;
            rout    = alu_ok ? onehot(rb) : '0;
            illegal = illegal_op;
         end
         T4: begin
            rout   = onehot(rc);
            alu_op = alu_code;
         end
         T5:      rin = onehot(ra);
         default: ;
      endcase
   end

   assign cs.PCout   = strb.pc_out;
   assign cs.Zlowout = strb.zlow_out;
   assign cs.MDRout  = strb.mdr_out;
   assign cs.MARin   = strb.mar_in;
   assign cs.Zin     = strb.z_in;
   assign cs.PCin    = strb.pc_in;
   assign cs.MDRin   = strb.mdr_in;
   assign cs.IRin    = strb.ir_in;
   assign cs.IncPC   = strb.inc_pc;
   assign cs.Read    = strb.read;
   assign cs.Busy    = strb.busy;
   assign cs.Halted  = strb.halted;
   assign cs.Yin     = y_in;
   assign cs.Rin     = rin;
   assign cs.Rout    = rout;
   assign cs.AluOp   = alu_op;
   assign cs.Illegal = illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a small single-bus datapath closes the fetch loop, and a
// scoreboard of hand-built per-cycle strobe vectors is checked by a free-running monitor.
module tb_control_sequencer;

   typedef struct packed {
      logic        pcout, zlowout, mdrout, marin, zin, pcin, mdrin, irin, yin, incpc, read;
      logic [15:0] rin;
      logic [15:0] rout;
      logic [3:0]  aluop;
      logic        busy, halted, illegal;
   } vec_t;

   typedef struct {
      vec_t  v;
      string tag;
   } exp_t;

   logic Clock = 1'b0;
   logic Resetn;
   logic dp_init;

   int n_vec = 0;
   int n_bad = 0;
   exp_t exp_q[$];

   control_sequencer_if #(.NREG(16), .ALUW(4)) cs ();

   control_sequencer #(.NREG(16), .OPW(5), .ALUW(4)) dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .cs     (cs)
   );

   always #5 Clock = ~Clock;

   // ---------------- datapath model ----------------
   logic [31:0] pc_q, mar_q, mdr_q, ir_q, y_q, z_q, bus;
   logic [31:0] regs [16];
   logic [31:0] mem  [64];

   assign cs.IR = ir_q;

   always_comb begin
      bus = '0;
      if (cs.PCout)   bus = bus | pc_q;
      if (cs.Zlowout) bus = bus | z_q;
      if (cs.MDRout)  bus = bus | mdr_q;
      for (int i = 0; i < 16; i++)
         if (cs.Rout[i]) bus = bus | regs[i];
   end

   function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, b);
      case (op)
         4'd1:    return a + b;
         4'd2:    return a - b;
         4'd3:    return a & b;
         4'd4:    return a | b;
         default: return b;
      endcase
   endfunction

   always @(posedge Clock) begin
      if (dp_init) begin
         pc_q <= '0; mar_q <= '0; mdr_q <= '0; ir_q <= '0; y_q <= '0; z_q <= '0;
         for (int i = 0; i < 16; i++) regs[i] <= '0;
         regs[3] <= 32'h55;
         regs[4] <= 32'h12;
         regs[5] <= 32'h14;
      end else begin
         if (cs.MARin)            mar_q <= bus;
         if (cs.Zin)              z_q   <= cs.IncPC ? bus + 32'd1 : alu(cs.AluOp, y_q, bus);
         if (cs.PCin)             pc_q  <= bus;
         if (cs.MDRin && cs.Read) mdr_q <= mem[mar_q[5:0]];
         if (cs.IRin)             ir_q  <= bus;
         if (cs.Yin)              y_q   <= bus;
         for (int i = 0; i < 16; i++)
            if (cs.Rin[i]) regs[i] <= bus;
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic vec_t sample();
      vec_t s;
      s = '{cs.PCout, cs.Zlowout, cs.MDRout, cs.MARin, cs.Zin, cs.PCin, cs.MDRin, cs.IRin,
            cs.Yin, cs.IncPC, cs.Read, cs.Rin, cs.Rout, cs.AluOp, cs.Busy, cs.Halted,
            cs.Illegal};
      return s;
   endfunction

   // Monitor: every cycle with an expectation pending, pop one and compare the whole
   // strobe vector; bus-driver exclusivity and one-hot register strobes hold every cycle.
   always @(negedge Clock) begin
      vec_t got;
      exp_t e;
      int   drivers;
      if (Resetn === 1'b1) begin
         got = sample();
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, 64'(got), 64'(e.v));
         end
         drivers = int'(got.pcout) + int'(got.zlowout) + int'(got.mdrout) + int'(|got.rout);
         check("bus_exclusive", 64'(drivers <= 1), 64'd1);
         check("reg_onehot", 64'($onehot0(got.rin) && $onehot0(got.rout)), 64'd1);
      end
   end

   // ---------------- expectation builders ----------------
   task automatic push(input vec_t v, input string tag);
      exp_t e;
      e.v = v;
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic exp_idle(input int n);
      for (int i = 0; i < n; i++) push('0, "IDLE");
   endtask

   task automatic exp_fetch(input int waits);
      vec_t v;
      v = '0; v.pcout = 1; v.marin = 1; v.incpc = 1; v.zin = 1; v.busy = 1;
      push(v, "T0");
      v = '0; v.zlowout = 1; v.pcin = 1; v.read = 1; v.mdrin = 1; v.busy = 1;
      for (int i = 0; i <= waits; i++) push(v, "T1");
      v = '0; v.mdrout = 1; v.irin = 1; v.busy = 1;
      push(v, "T2");
   endtask

   task automatic exp_t3(input logic yin, input int rb, input logic ill);
      vec_t v;
      v = '0; v.busy = 1; v.yin = yin; v.illegal = ill;
      if (yin) v.rout = 16'(1) << rb;
      push(v, "T3");
   endtask

   task automatic exp_t4(input int rc, input logic [3:0] code);
      vec_t v;
      v = '0; v.busy = 1; v.zin = 1; v.aluop = code; v.rout = 16'(1) << rc;
      push(v, "T4");
   endtask

   task automatic exp_alu(input int ra, input int rb, input int rc, input logic [3:0] code);
      vec_t v;
      exp_t3(1'b1, rb, 1'b0);
      exp_t4(rc, code);
      v = '0; v.busy = 1; v.zlowout = 1; v.rin = 16'(1) << ra;
      push(v, "T5");
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      vec_t hv;
      Resetn    = 1'b0;
      dp_init   = 1'b1;
      cs.Run    = 1'b0;
      cs.MemRdy = 1'b1;
      for (int i = 0; i < 64; i++) mem[i] = 32'hD000_0000;
      mem[0] = 32'h22A0_0000;   // SUB R5 = R4 - R0
      mem[1] = 32'h1B2A_0000;   // ADD R6 = R5 + R4
      mem[2] = 32'h3432_8000;   // OR  R8 = R6 | R5
      mem[3] = 32'h2BC3_0000;   // AND R7 = R8 & R6
      mem[4] = 32'hD000_0000;   // NOP
      mem[5] = 32'h2199_8000;   // SUB R3 = R3 - R3
      mem[6] = 32'hF800_0000;   // undefined opcode 11111
      mem[7] = 32'hD000_0000;   // NOP
      mem[8] = 32'hD800_0000;   // HALT
      mem[9] = 32'h1D22_8000;   // ADD R10 = R4 + R5 (aborted in T4)

      #3;
      check("reset_outputs", 64'(sample()), 64'd0);
      cyc(2);
      dp_init = 1'b0;
      Resetn  = 1'b1;
      cyc(1);

      // SUB with MemRdy tied high; Run dropped during T0 still completes, then IDLE.
      exp_idle(1); exp_fetch(0); exp_alu(5, 4, 0, 4'd2); exp_idle(2);
      cs.Run = 1'b1;
      cyc(1);
      cs.Run = 1'b0;
      cyc(8);
      check("sub_r5", 64'(regs[5]), 64'h12);
      check("pc_after_sub", 64'(pc_q), 64'd1);
      check("q_drained_1", 64'(exp_q.size()), 64'd0);

      // ADD with three T1 wait states: nine cycles end to end.
      cs.MemRdy = 1'b0;
      exp_idle(1); exp_fetch(3); exp_alu(6, 5, 4, 4'd1); exp_idle(2);
      cs.Run = 1'b1;
      cyc(1);
      cs.Run = 1'b0;
      cyc(4);
      cs.MemRdy = 1'b1;
      cyc(7);
      check("add_r6", 64'(regs[6]), 64'h24);
      check("pc_after_add", 64'(pc_q), 64'd2);
      check("q_drained_2", 64'(exp_q.size()), 64'd0);

      // Back-to-back OR / AND / NOP / SUB R3=R3-R3 with Run held high.
      exp_idle(1);
      exp_fetch(0); exp_alu(8, 6, 5, 4'd4);
      exp_fetch(0); exp_alu(7, 8, 6, 4'd3);
      exp_fetch(0); exp_t3(1'b0, 0, 1'b0);
      exp_fetch(0); exp_alu(3, 3, 3, 4'd2);
      exp_idle(2);
      cs.Run = 1'b1;
      cyc(18);
      cs.Run = 1'b0;
      cyc(7);
      check("or_r8", 64'(regs[8]), 64'h36);
      check("and_r7", 64'(regs[7]), 64'h24);
      check("self_sub_r3", 64'(regs[3]), 64'h0);
      check("pc_after_prog", 64'(pc_q), 64'd6);
      check("q_drained_3", 64'(exp_q.size()), 64'd0);

      // Undefined opcode: one-cycle Illegal in T3, no register write, straight to T0.
      exp_idle(1);
      exp_fetch(0); exp_t3(1'b0, 0, 1'b1);
      exp_fetch(0); exp_t3(1'b0, 0, 1'b0);
      exp_idle(2);
      cs.Run = 1'b1;
      cyc(5);
      cs.Run = 1'b0;
      cyc(6);
      check("pc_after_illegal", 64'(pc_q), 64'd8);
      check("q_drained_4", 64'(exp_q.size()), 64'd0);

      // HALT ignores Run toggling; only reset leaves it.
      hv = '0; hv.halted = 1;
      exp_idle(1); exp_fetch(0); exp_t3(1'b0, 0, 1'b0);
      for (int i = 0; i < 6; i++) push(hv, "HALT");
      cs.Run = 1'b1;
      cyc(6);
      cs.Run = 1'b0;
      cyc(2);
      cs.Run = 1'b1;
      cyc(2);
      cs.Run = 1'b0;
      cyc(1);
      Resetn = 1'b0;
      #1;
      check("halt_reset_outputs", 64'(sample()), 64'd0);
      cyc(1);
      Resetn = 1'b1;
      exp_idle(2);
      cyc(2);
      check("pc_after_halt", 64'(pc_q), 64'd9);
      check("q_drained_5", 64'(exp_q.size()), 64'd0);

      // Asynchronous reset in the middle of T4 drops every strobe at once.
      exp_idle(1); exp_fetch(0); exp_t3(1'b1, 4, 1'b0); exp_t4(5, 4'd1);
      cs.Run = 1'b1;
      cyc(1);
      cs.Run = 1'b0;
      cyc(4);
      @(negedge Clock);
      #1;
      Resetn = 1'b0;
      #1;
      check("async_reset_t4", 64'(sample()), 64'd0);
      cyc(1);
      Resetn = 1'b1;
      check("aborted_r10", 64'(regs[10]), 64'h0);
      check("pc_after_abort", 64'(pc_q), 64'd10);
      exp_idle(2);
      cyc(2);
      check("q_drained_6", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
